// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: buffers CPU TX bytes in a FIFO and sequences them into the
// transmitter. Captures received bytes and raises a level interrupt until software services them.
module uart_mmio_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] access_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_begin,
    input  logic        uart_tx_busy,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_done,
    output logic        int_req
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_RXDATA = BASE_ADDR + 32'h8;
    localparam logic [31:0] ADDR_INTACK = BASE_ADDR + 32'hC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_t;

    tx_state_t        state;
    logic [1:0]       hi_cnt;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ovf;
    logic             tx_ovf;

    logic hit_tx_c, hit_status_c, hit_rx_c, hit_ack_c;
    logic fifo_empty_c, fifo_full_c, push_c, pop_c;
    logic rx_read_c, ack_c, rx_clear_c;
    logic [31:0] status_c;
    logic unused_wdata;

    assign hit_tx_c     = (access_addr == ADDR_TXDATA);
    assign hit_status_c = (access_addr == ADDR_STATUS);
    assign hit_rx_c     = (access_addr == ADDR_RXDATA);
    assign hit_ack_c    = (access_addr == ADDR_INTACK);

    // Full: same index, opposite wrap bit.
    assign fifo_empty_c = (wr_ptr == rd_ptr);
    assign fifo_full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                          (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign push_c       = bus_we && hit_tx_c && !fifo_full_c;
    assign pop_c        = (state == IDLE) && !fifo_empty_c && !uart_tx_busy;

    assign rx_read_c    = bus_re && hit_rx_c;
    assign ack_c        = (bus_we || bus_re) && hit_ack_c;
    assign rx_clear_c   = rx_read_c || ack_c;
    assign status_c     = {27'b0, rx_ovf, tx_ovf, rx_valid, fifo_full_c, fifo_empty_c};
    assign unused_wdata = ^bus_wdata[31:8];

    // FIFO storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + CNT_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    // TX sequencer; uart_tx_begin is high exactly while in START.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hi_cnt        <= 2'd0;
            uart_tx_data  <= 8'h00;
            uart_tx_begin <= 1'b0;
        end else begin
            uart_tx_begin <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        uart_tx_data  <= fifo_mem[rd_ptr[PTR_W-1:0]];
                        uart_tx_begin <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    hi_cnt <= 2'd0;
                    state  <= WAIT_HI;
                end
                WAIT_HI: begin
                    // Give up on the busy handshake after 4 cycles so a silent transmitter cannot hang us.
                    if (uart_tx_busy || hi_cnt == 2'd3) begin
                        state <= WAIT_LO;
                    end else begin
                        hi_cnt <= hi_cnt + 2'd1;
                    end
                end
                WAIT_LO: begin
                    if (!uart_tx_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file, RX capture and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_ovf    <= 1'b0;
            tx_ovf    <= 1'b0;
            int_req   <= 1'b0;
            bus_rdata <= 32'h0;
        end else begin
            int_req <= rx_valid | rx_ovf;

            if (uart_rx_done) begin
                // A byte arriving alongside a clear wins and leaves the overflow flag alone.
                rx_byte  <= uart_rx_data;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_clear_c) rx_ovf <= 1'b1;
            end else begin
                if (rx_clear_c) rx_valid <= 1'b0;
                if (ack_c)      rx_ovf   <= 1'b0;
            end

            if (ack_c) begin
                tx_ovf <= 1'b0;
            end else if (bus_we && hit_tx_c && fifo_full_c) begin
                tx_ovf <= 1'b1;
            end

            if (bus_re) begin
                if (hit_status_c)   bus_rdata <= status_c;
                else if (hit_rx_c)  bus_rdata <= {24'b0, rx_byte};
                else                bus_rdata <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with a simple transmitter model (busy for 10 cycles per byte).
module tb_uart_mmio_ctrl;

    localparam logic [31:0] A_TX   = 32'h0000_0400;
    localparam logic [31:0] A_STAT = 32'h0000_0404;
    localparam logic [31:0] A_RX   = 32'h0000_0408;
    localparam logic [31:0] A_ACK  = 32'h0000_040C;
    localparam logic [31:0] A_OUT  = 32'h0000_0410;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] access_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_begin;
    logic        uart_tx_busy;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_done;
    logic        int_req;

    logic        hold_busy;
    logic        model_busy;
    int          begin_cnt;
    int          width_err;
    logic [7:0]  tx_log[$];

    int n_checks = 0;
    int n_errors = 0;

    assign uart_tx_busy = hold_busy | model_busy;

    always #10 clk = ~clk;

    uart_mmio_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .access_addr  (access_addr),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .uart_tx_data (uart_tx_data),
        .uart_tx_begin(uart_tx_begin),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .int_req      (int_req)
    );

    // Transmitter model: logs each begin pulse and goes busy for 10 cycles.
    initial begin
        int   busy_left;
        logic prev_begin;
        busy_left  = 0;
        prev_begin = 1'b0;
        model_busy = 1'b0;
        begin_cnt  = 0;
        width_err  = 0;
        forever begin
            @(negedge clk);
            if (uart_tx_begin) begin
                if (prev_begin) width_err++;
                else begin
                    begin_cnt++;
                    tx_log.push_back(uart_tx_data);
                    busy_left = 10;
                end
            end
            prev_begin = uart_tx_begin;
            if (busy_left > 0) begin
                model_busy = 1'b1;
                busy_left--;
            end else begin
                model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        access_addr = addr;
        bus_wdata   = data;
        bus_we      = 1'b1;
        @(negedge clk);
        bus_we      = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        access_addr = addr;
        bus_re      = 1'b1;
        @(negedge clk);
        bus_re      = 1'b0;
        data        = bus_rdata;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        uart_rx_data = b;
        uart_rx_done = 1'b1;
        @(negedge clk);
        uart_rx_done = 1'b0;
    endtask

    // Wait until n bytes are logged and the line is idle, bounded by budget cycles.
    task automatic wait_tx(input string tag, input int n, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (tx_log.size() >= n && !uart_tx_busy) break;
        end
        repeat (3) @(negedge clk);
        check(tag, 32'(tx_log.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] rd;
        int base;

        rst          = 1'b1;
        access_addr  = 32'h0;
        bus_we       = 1'b0;
        bus_re       = 1'b0;
        bus_wdata    = 32'h0;
        uart_rx_data = 8'h00;
        uart_rx_done = 1'b0;
        hold_busy    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_int", 32'(int_req), 32'h0);
        check("rst_txdata", 32'(uart_tx_data), 32'h0);
        bus_read(A_STAT, rd);
        check("rst_status", rd, 32'h1);
        bus_read(A_OUT, rd);
        check("out_of_window", rd, 32'h0);
        bus_read(A_ACK, rd);
        check("intack_read", rd, 32'h0);
        check("rst_no_begin", 32'(begin_cnt), 32'd0);

        // 2: two bytes through the transmitter
        bus_write(A_TX, 32'h0000_0041);
        bus_write(A_TX, 32'hFFFF_FF42);
        wait_tx("t2_count", 2, 200);
        check("t2_byte0", 32'(tx_log[0]), 32'h41);
        check("t2_byte1", 32'(tx_log[1]), 32'h42);
        check("t2_pulses", 32'(begin_cnt), 32'd2);
        bus_read(A_STAT, rd);
        check("t2_status", rd, 32'h1);

        // 3: fill FIFO while busy, overflow, then drain in order
        base = tx_log.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) bus_write(A_TX, 32'(8'h60 + 8'(i)));
        bus_read(A_STAT, rd);
        check("t3_status_full", rd, 32'h0A);
        check("t3_no_begin", 32'(begin_cnt), 32'(base));
        hold_busy = 1'b0;
        wait_tx("t3_count", base + 16, 1000);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_byte%0d", i), 32'(tx_log[base + i]), 32'(8'h60 + 8'(i)));
        end
        bus_read(A_STAT, rd);
        check("t3_status_drained", rd, 32'h09);
        bus_write(A_ACK, 32'h0);
        bus_read(A_STAT, rd);
        check("t3_status_ack", rd, 32'h01);

        // 4: single RX byte and interrupt timing
        rx_pulse(8'h5A);
        @(negedge clk);
        check("t4_int_set", 32'(int_req), 32'h1);
        bus_read(A_RX, rd);
        check("t4_rxdata", rd, 32'h5A);
        check("t4_int_lag", 32'(int_req), 32'h1);
        @(negedge clk);
        check("t4_int_clr", 32'(int_req), 32'h0);

        // 5: RX overrun, then INTACK clears everything
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(A_STAT, rd);
        check("t5_status_ovf", rd, 32'h15);
        bus_read(A_RX, rd);
        check("t5_rxdata", rd, 32'h22);
        bus_write(A_ACK, 32'h0);
        bus_read(A_STAT, rd);
        check("t5_status_ack", rd, 32'h01);
        check("t5_int", 32'(int_req), 32'h0);

        // RX byte in the same cycle as an RXDATA read: new byte survives, no overflow
        @(negedge clk);
        access_addr  = A_RX;
        bus_re       = 1'b1;
        uart_rx_data = 8'h33;
        uart_rx_done = 1'b1;
        @(negedge clk);
        bus_re       = 1'b0;
        uart_rx_done = 1'b0;
        check("t5_race_old", bus_rdata, 32'h22);
        bus_read(A_STAT, rd);
        check("t5_race_status", rd, 32'h05);
        bus_read(A_RX, rd);
        check("t5_race_new", rd, 32'h33);
        bus_write(A_ACK, 32'h0);

        // 6: reset while waiting on a frame with 3 bytes queued
        base = begin_cnt;
        bus_write(A_TX, 32'h0000_0070);
        bus_write(A_TX, 32'h0000_0071);
        bus_write(A_TX, 32'h0000_0072);
        bus_write(A_TX, 32'h0000_0073);
        check("t6_started", 32'(begin_cnt), 32'(base + 1));
        bus_read(A_STAT, rd);
        check("t6_status_queued", rd, 32'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_begin_low", 32'(uart_tx_begin), 32'h0);
        bus_read(A_STAT, rd);
        check("t6_status_flushed", rd, 32'h01);
        repeat (40) @(negedge clk);
        check("t6_no_more_begin", 32'(begin_cnt), 32'(base + 1));
        check("begin_width", 32'(width_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
